mips_decode_unit: RTL and testbench

- Registered instruction decoder for a 5-stage MIPS pipeline: main control (opcode/func → datapath controls) plus ALU control (alu_op/func → 4-bit ALU function).
- Sits in ID; all outputs feed the ID/EX boundary.

---
 rtl/mips_decode_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mips_decode_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_unit.sv
// mips_decode_unit
// ----------------------------------------------------------------------------
// Registered instruction decoder for the ID stage of a 5-stage MIPS pipeline.
// Main control (opcode/func -> datapath controls) and ALU control
// (alu_op/func -> 4-bit ALU function) are decoded combinationally and every
// output is registered, so all outputs are stable for the ID/EX boundary and
// change only on a clock edge or on asynchronous reset.
//
// Ports
//   clk            rising-edge clock
//   rst_b          asynchronous active-low reset (outputs 0, control = ADD)
//   opcode, func   inst[31:26], inst[5:0]
//   has_hazard     force a bubble into the next registered value
//   reg_dst .. halted  registered decode outputs (see field comments below)
//
// Optional build macro
//   DECODE_TRACE_EN  adds a 32-bit cycle counter and a per-cycle simulation
//                    print of counter, is_imm, is_src1_valid, is_src2_valid,
//                    has_hazard. Decode behaviour is identical either way.
// ----------------------------------------------------------------------------
module mips_decode_unit (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       has_hazard,
    output logic       reg_dst,
    output logic [1:0] alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       cache_en,
    output logic       is_LB_SB,
    output logic [2:0] branch,
    output logic [1:0] jump,
    output logic       jr,
    output logic [3:0] alu_op,
    output logic [3:0] control,
    output logic       do_extend,
    output logic       is_imm,
    output logic       is_src1_valid,
    output logic       is_src2_valid,
    output logic       halted
);

    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_NONE = 4'b1111;

    // ALU control: maps the main-control alu_op (and func for R-type) to the
    // ALU function code.
    function automatic logic [3:0] alu_control(input logic [3:0] op, input logic [5:0] fn);
        logic [3:0] ctl;
        case (op)
            4'b0000: ctl = 4'b0010;
            4'b0001: ctl = 4'b0011;
            4'b0010: ctl = 4'b0100;
            4'b0011: begin
                case (fn)
                    6'h20:        ctl = 4'b0010;
                    6'h21:        ctl = 4'b0011;
                    6'h22:        ctl = 4'b0100;
                    6'h23:        ctl = 4'b0101;
                    6'h24:        ctl = 4'b0000;
                    6'h25:        ctl = 4'b0001;
                    6'h26:        ctl = 4'b0110;
                    6'h27:        ctl = 4'b0111;
                    6'h2A:        ctl = 4'b1000;
                    6'h2B:        ctl = 4'b1001;
                    6'h00, 6'h04: ctl = 4'b1010;
                    6'h02, 6'h06: ctl = 4'b1011;
                    6'h03, 6'h07: ctl = 4'b1100;
                    default:      ctl = 4'b1111;
                endcase
            end
            4'b0100: ctl = 4'b0000;
            4'b0101: ctl = 4'b0001;
            4'b0110: ctl = 4'b0110;
            4'b0111: ctl = 4'b1000;
            4'b1000: ctl = 4'b1001;
            4'b1001: ctl = 4'b1101;
            default: ctl = 4'b1111;
        endcase
        return ctl;
    endfunction

    logic       reg_dst_d, mem_to_reg_d, reg_write_d, mem_read_d, mem_write_d;
    logic       cache_en_d, is_lb_sb_d, jr_d, do_extend_d, is_imm_d;
    logic       src1_d, src2_d, halted_d, decoded_s;
    logic [1:0] alu_src_d, jump_d;
    logic [2:0] branch_d;
    logic [3:0] alu_op_d, control_d;

    logic       reg_dst_q, mem_to_reg_q, reg_write_q, mem_read_q, mem_write_q;
    logic       cache_en_q, is_lb_sb_q, jr_q, do_extend_q, is_imm_q;
    logic       src1_q, src2_q, halted_q;
    logic [1:0] alu_src_q, jump_q;
    logic [2:0] branch_q;
    logic [3:0] alu_op_q, control_q;

    // Main decode: start from a bubble, fill in fields for recognised opcodes.
    // Hazards and unknown opcodes leave the bubble untouched.
    always_comb begin
        reg_dst_d    = 1'b0;
        alu_src_d    = 2'b00;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        is_lb_sb_d   = 1'b0;
        branch_d     = 3'b000;
        jump_d       = 2'b00;
        jr_d         = 1'b0;
        alu_op_d     = 4'b0000;
        do_extend_d  = 1'b0;
        src1_d       = 1'b0;
        src2_d       = 1'b0;
        halted_d     = 1'b0;
        decoded_s    = 1'b1;
        if (has_hazard) begin
            decoded_s = 1'b0;
        end else begin
            case (opcode)
                6'h00: begin
                    reg_dst_d = 1'b1;
                    alu_op_d  = 4'b0011;
                    src1_d    = 1'b1;
                    src2_d    = 1'b1;
                    case (func)
                        6'h08: begin
                            jr_d   = 1'b1;
                            src2_d = 1'b0;
                        end
                        6'h0C: begin
                            halted_d = 1'b1;
                            src1_d   = 1'b0;
                            src2_d   = 1'b0;
                        end
                        // Immediate shifts take A from shamt, not rs.
                        6'h00, 6'h02, 6'h03: begin
                            alu_src_d   = 2'b01;
                            src1_d      = 1'b0;
                            reg_write_d = 1'b1;
                        end
                        default: reg_write_d = 1'b1;
                    endcase
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    alu_src_d   = 2'b10;
                    reg_write_d = 1'b1;
                    src1_d      = (opcode != 6'h0F);
                    // Arithmetic/compare immediates sign-extend; logical and lui do not.
                    do_extend_d = (opcode <= 6'h0B);
                    case (opcode[2:0])
                        3'd0:    alu_op_d = 4'b0000;
                        3'd1:    alu_op_d = 4'b0001;
                        3'd2:    alu_op_d = 4'b0111;
                        3'd3:    alu_op_d = 4'b1000;
                        3'd4:    alu_op_d = 4'b0100;
                        3'd5:    alu_op_d = 4'b0101;
                        3'd6:    alu_op_d = 4'b0110;
                        default: alu_op_d = 4'b1001;
                    endcase
                end
                6'h20, 6'h23: begin
                    alu_src_d    = 2'b10;
                    do_extend_d  = 1'b1;
                    mem_read_d   = 1'b1;
                    mem_to_reg_d = 1'b1;
                    reg_write_d  = 1'b1;
                    src1_d       = 1'b1;
                    is_lb_sb_d   = (opcode == 6'h20);
                end
                6'h28, 6'h2B: begin
                    alu_src_d   = 2'b10;
                    do_extend_d = 1'b1;
                    mem_write_d = 1'b1;
                    src1_d      = 1'b1;
                    src2_d      = 1'b1;
                    is_lb_sb_d  = (opcode == 6'h28);
                end
                6'h04, 6'h05, 6'h06, 6'h07: begin
                    alu_op_d    = 4'b0010;
                    do_extend_d = 1'b1;
                    src1_d      = 1'b1;
                    src2_d      = ~opcode[1];
                    branch_d    = {1'b0, opcode[1:0]} + 3'd1;
                end
                6'h02: begin
                    jump_d   = 2'b01;
                    alu_op_d = 4'b1111;
                end
                6'h03: begin
                    jump_d      = 2'b10;
                    reg_write_d = 1'b1;
                    alu_op_d    = 4'b1111;
                end
                default: decoded_s = 1'b0;
            endcase
        end
        if (decoded_s) begin
            control_d = alu_control(alu_op_d, func);
        end else begin
            control_d = CTL_ADD;
        end
        is_imm_d   = alu_src_d[1];
        cache_en_d = mem_read_d | mem_write_d;
    end

    // Output register; reset holds a bubble with the ALU parked on ADD.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            reg_dst_q <= 1'b0; alu_src_q <= 2'b00; mem_to_reg_q <= 1'b0;
            reg_write_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0;
            cache_en_q <= 1'b0; is_lb_sb_q <= 1'b0; branch_q <= 3'b000;
            jump_q <= 2'b00; jr_q <= 1'b0; alu_op_q <= 4'b0000;
            control_q <= CTL_ADD; do_extend_q <= 1'b0; is_imm_q <= 1'b0;
            src1_q <= 1'b0; src2_q <= 1'b0; halted_q <= 1'b0;
        end else begin
            reg_dst_q <= reg_dst_d; alu_src_q <= alu_src_d; mem_to_reg_q <= mem_to_reg_d;
            reg_write_q <= reg_write_d; mem_read_q <= mem_read_d; mem_write_q <= mem_write_d;
            cache_en_q <= cache_en_d; is_lb_sb_q <= is_lb_sb_d; branch_q <= branch_d;
            jump_q <= jump_d; jr_q <= jr_d; alu_op_q <= alu_op_d;
            control_q <= control_d; do_extend_q <= do_extend_d; is_imm_q <= is_imm_d;
            src1_q <= src1_d; src2_q <= src2_d; halted_q <= halted_d;
        end
    end

    assign reg_dst       = reg_dst_q;
    assign alu_src       = alu_src_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign reg_write     = reg_write_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign cache_en      = cache_en_q;
    assign is_LB_SB      = is_lb_sb_q;
    assign branch        = branch_q;
    assign jump          = jump_q;
    assign jr            = jr_q;
    assign alu_op        = alu_op_q;
    assign control       = control_q;
    assign do_extend     = do_extend_q;
    assign is_imm        = is_imm_q;
    assign is_src1_valid = src1_q;
    assign is_src2_valid = src2_q;
    assign halted        = halted_q;

`ifdef DECODE_TRACE_EN
    logic [31:0] cycle_cnt_d, cycle_cnt_q;

    // Free-running trace cycle counter.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    // Trace counter register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cycle_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Per-cycle simulation trace of operand-usage flags.
    always @(posedge clk) begin
        $display("decode_trace cycle=%0d is_imm=%0b src1=%0b src2=%0b hazard=%0b",
                 cycle_cnt_q, is_imm_q, src1_q, src2_q, has_hazard);
    end
`else
`endif

endmodule

// File: tb/tb_mips_decode_unit.sv
// Self-checking bench for mips_decode_unit: an instruction-level reference
// model predicts the registered outputs one cycle after each input, a compare
// process checks every cycle, and directed cases pin the model with literals.
module tb_mips_decode_unit;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       cache_en;
        logic       is_lb_sb;
        logic [2:0] branch;
        logic [1:0] jump;
        logic       jr;
        logic [3:0] alu_op;
        logic [3:0] control;
        logic       do_extend;
        logic       is_imm;
        logic       src1;
        logic       src2;
        logic       halted;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] func = 6'h00;
    logic       has_hazard = 1'b0;

    logic       reg_dst, mem_to_reg, reg_write, mem_read, mem_write, cache_en;
    logic       is_LB_SB, jr, do_extend, is_imm, is_src1_valid, is_src2_valid, halted;
    logic [1:0] alu_src, jump;
    logic [2:0] branch;
    logic [3:0] alu_op, control;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    dec_t exp_q;
    dec_t dut_v;
    dec_t bubble;

    mips_decode_unit dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func), .has_hazard(has_hazard),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .cache_en(cache_en), .is_LB_SB(is_LB_SB), .branch(branch), .jump(jump),
        .jr(jr), .alu_op(alu_op), .control(control), .do_extend(do_extend),
        .is_imm(is_imm), .is_src1_valid(is_src1_valid),
        .is_src2_valid(is_src2_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    assign dut_v = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                    cache_en, is_LB_SB, branch, jump, jr, alu_op, control,
                    do_extend, is_imm, is_src1_valid, is_src2_valid, halted};

    function automatic dec_t bubble_val();
        dec_t d = '0;
        d.control = 4'b0010;
        return d;
    endfunction

    // R-type ALU function by name.
    function automatic logic [3:0] rtype_ctl(input logic [5:0] fn);
        case (fn)
            6'h24: return 4'b0000;  // and
            6'h25: return 4'b0001;  // or
            6'h20: return 4'b0010;  // add
            6'h21: return 4'b0011;  // addu
            6'h22: return 4'b0100;  // sub
            6'h23: return 4'b0101;  // subu
            6'h26: return 4'b0110;  // xor
            6'h27: return 4'b0111;  // nor
            6'h2A: return 4'b1000;  // slt
            6'h2B: return 4'b1001;  // sltu
            6'h00, 6'h04: return 4'b1010;
            6'h02, 6'h06: return 4'b1011;
            6'h03, 6'h07: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    // Instruction-level model of what the decoder must produce.
    function automatic dec_t model(input logic [5:0] op, input logic [5:0] fn, input logic hz);
        logic [3:0] imm_aluop [8];
        logic [3:0] imm_ctl   [8];
        dec_t d = bubble_val();
        imm_aluop = '{4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b0100, 4'b0101, 4'b0110, 4'b1001};
        imm_ctl   = '{4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b0000, 4'b0001, 4'b0110, 4'b1101};
        if (hz) return d;
        if (op == 6'h00) begin
            d.reg_dst = 1'b1; d.alu_op = 4'b0011;
            if (fn == 6'h08) begin
                d.jr = 1'b1; d.src1 = 1'b1; d.control = 4'b1111;
            end else if (fn == 6'h0C) begin
                d.halted = 1'b1; d.control = 4'b1111;
            end else begin
                d.reg_write = 1'b1; d.src1 = 1'b1; d.src2 = 1'b1;
                d.control = rtype_ctl(fn);
                if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                    d.alu_src = 2'b01; d.src1 = 1'b0;
                end
            end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            d.alu_src = 2'b10; d.is_imm = 1'b1; d.reg_write = 1'b1;
            d.src1 = (op != 6'h0F);
            d.do_extend = (op < 6'h0C);
            d.alu_op = imm_aluop[op - 6'h08];
            d.control = imm_ctl[op - 6'h08];
        end else if (op == 6'h20 || op == 6'h23) begin
            d.alu_src = 2'b10; d.is_imm = 1'b1; d.do_extend = 1'b1;
            d.mem_read = 1'b1; d.mem_to_reg = 1'b1; d.reg_write = 1'b1;
            d.cache_en = 1'b1; d.src1 = 1'b1; d.is_lb_sb = (op == 6'h20);
        end else if (op == 6'h28 || op == 6'h2B) begin
            d.alu_src = 2'b10; d.is_imm = 1'b1; d.do_extend = 1'b1;
            d.mem_write = 1'b1; d.cache_en = 1'b1; d.src1 = 1'b1; d.src2 = 1'b1;
            d.is_lb_sb = (op == 6'h28);
        end else if (op >= 6'h04 && op <= 6'h07) begin
            d.alu_op = 4'b0010; d.control = 4'b0100; d.do_extend = 1'b1; d.src1 = 1'b1;
            d.src2 = (op == 6'h04 || op == 6'h05);
            case (op)
                6'h04:   d.branch = 3'b001;
                6'h05:   d.branch = 3'b010;
                6'h06:   d.branch = 3'b011;
                default: d.branch = 3'b100;
            endcase
        end else if (op == 6'h02 || op == 6'h03) begin
            d.alu_op = 4'b1111; d.control = 4'b1111;
            d.jump = (op == 6'h02) ? 2'b01 : 2'b10;
            d.reg_write = (op == 6'h03);
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Expected output register: model of the inputs seen at each edge.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) exp_q <= bubble_val();
        else        exp_q <= model(opcode, func, has_hazard);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) check("model", 32'(dut_v), 32'(exp_q));
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic hz);
        @(posedge clk); #1;
        opcode = op; func = fn; has_hazard = hz;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        bubble = bubble_val();
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        check("reset_state", 32'(dut_v), 32'(bubble));
        chk_en = 1'b1;

        drive(6'h00, 6'h20, 1'b0);  // add
        check("add_reg_dst", 32'(reg_dst), 32'd1);
        check("add_reg_write", 32'(reg_write), 32'd1);
        check("add_alu_op", 32'(alu_op), 32'h3);
        check("add_control", 32'(control), 32'h2);
        check("add_srcs", 32'({is_src1_valid, is_src2_valid}), 32'h3);

        // Asynchronous reset mid-run, checked between clock edges.
        #1 rst_b = 1'b0;
        #1 check("async_reset", 32'(dut_v), 32'(bubble));
        @(posedge clk); #1 rst_b = 1'b1;

        drive(6'h00, 6'h03, 1'b0);  // sra
        check("sra_alu_src", 32'(alu_src), 32'h1);
        check("sra_control", 32'(control), 32'hC);
        check("sra_src1", 32'(is_src1_valid), 32'd0);

        drive(6'h20, 6'h15, 1'b0);  // lb
        check("lb_mem", 32'({mem_read, mem_to_reg, is_LB_SB, cache_en}), 32'hF);
        check("lb_alu_src", 32'(alu_src), 32'h2);
        check("lb_ext_ctl", 32'({do_extend, control}), 32'h12);

        drive(6'h0D, 6'h00, 1'b0);  // ori
        check("ori_ext_ctl", 32'({do_extend, control}), 32'h01);

        drive(6'h05, 6'h2A, 1'b0);  // bne
        check("bne_branch", 32'(branch), 32'h2);
        check("bne_alu", 32'({alu_op, control}), 32'h24);
        check("bne_src2", 32'(is_src2_valid), 32'd1);

        drive(6'h03, 6'h00, 1'b0);  // jal
        check("jal_jump", 32'({jump, reg_write}), 32'h5);

        drive(6'h2B, 6'h00, 1'b1);  // sw under hazard
        check("hazard_sw", 32'({mem_write, cache_en}), 32'h0);
        check("hazard_bubble", 32'(dut_v), 32'(bubble));

        drive(6'h00, 6'h0C, 1'b0);  // syscall
        check("syscall", 32'({halted, reg_write}), 32'h2);

        drive(6'h3F, 6'h20, 1'b0);  // unknown opcode
        check("unknown_bubble", 32'(dut_v), 32'(bubble));

        // Back-to-back random instructions; the compare process checks latency.
        begin
            logic [5:0] ops [20];
            ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                    6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B};
            for (int i = 0; i < 600; i++) begin
                @(posedge clk); #1;
                opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 19)];
                func = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'($urandom_range(6'h20, 6'h2B));
                if ($urandom_range(0, 5) == 0) func = 6'($urandom_range(0, 12));
                has_hazard = ($urandom_range(0, 7) == 0);
            end
        end
        @(posedge clk); @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
